// File: rtl/p_logic_reduce.sv
// p_logic_reduce: sequential bitwise reduction engine.
// Captures NB_INS operand buses plus an operator in one input handshake,
// folds one operand per clock and holds the result behind a valid/ready
// output handshake. Supported operators are OR, AND, XOR, NOR, NAND and
// XNOR; the two reserved codes return zero and raise op_err.
module p_logic_reduce #(
   parameter int BUS_WIDTH = 4,
   parameter int NB_INS    = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2:0]           op,
   input  logic [BUS_WIDTH-1:0] in_buses [NB_INS-1:0],
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [BUS_WIDTH-1:0] out_bus,
   output logic                 op_err,
   output logic                 busy
);

   localparam int IDX_W = $clog2(NB_INS) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FOLD = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_nextState;

   logic [BUS_WIDTH-1:0] r_ops [NB_INS-1:0];
   logic [2:0]           r_op;
   logic [BUS_WIDTH-1:0] r_acc;
   logic [IDX_W-1:0]     r_idx;
   logic [BUS_WIDTH-1:0] r_outBus;
   logic                 r_opErr;

   logic                 w_accept;
   logic                 w_lastFold;
   logic [BUS_WIDTH-1:0] w_curOperand;
   logic [BUS_WIDTH-1:0] w_folded;

   // Base combining operator; the inverted flavours share the base of their
   // non-inverted partner and only differ in the final inversion.
   function automatic logic [BUS_WIDTH-1:0] baseOp(input logic [2:0] opc,
                                                   input logic [BUS_WIDTH-1:0] a,
                                                   input logic [BUS_WIDTH-1:0] b);
      case (opc)
         3'b001, 3'b100: return a & b;
         3'b010, 3'b101: return a ^ b;
         default:        return a | b;
      endcase
   endfunction

   // Turns the folded accumulator into the published result.
   function automatic logic [BUS_WIDTH-1:0] finalize(input logic [2:0] opc,
                                                     input logic [BUS_WIDTH-1:0] v);
      case (opc)
         3'b000, 3'b001, 3'b010: return v;
         3'b011, 3'b100, 3'b101: return ~v;
         default:                return '0;
      endcase
   endfunction

   function automatic logic isReserved(input logic [2:0] opc);
      return opc[2] & opc[1];
   endfunction

   assign w_accept   = (r_state == IDLE) && in_valid;
   assign w_lastFold = (r_idx == IDX_W'(NB_INS - 1));
   assign w_folded   = baseOp(r_op, r_acc, w_curOperand);

   // Select the captured operand addressed by the fold index.
   always_comb begin
      w_curOperand = '0;
      for (int i = 0; i < NB_INS; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_curOperand = r_ops[i];
         end
      end
   end

   // State register; reset aborts any in-flight transaction immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic: accept in IDLE, fold until the last operand, then
   // wait in DONE for the consumer.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_nextState = (NB_INS > 1) ? FOLD : DONE;
            end
         end
         FOLD: begin
            if (w_lastFold) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Datapath: operand capture, accumulation and the registered result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NB_INS; i++) begin
            r_ops[i] <= '0;
         end
         r_op     <= '0;
         r_acc    <= '0;
         r_idx    <= '0;
         r_outBus <= '0;
         r_opErr  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  for (int i = 0; i < NB_INS; i++) begin
                     r_ops[i] <= in_buses[i];
                  end
                  r_op  <= op;
                  r_acc <= in_buses[0];
                  r_idx <= IDX_W'(1);
                  if (NB_INS == 1) begin
                     r_outBus <= finalize(op, in_buses[0]);
                     r_opErr  <= isReserved(op);
                  end
               end
            end
            FOLD: begin
               r_acc <= w_folded;
               r_idx <= r_idx + IDX_W'(1);
               if (w_lastFold) begin
                  r_outBus <= finalize(r_op, w_folded);
                  r_opErr  <= isReserved(r_op);
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_outBus <= '0;
                  r_opErr  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE) && rst_n;
   assign busy      = (r_state != IDLE);
   assign out_valid = (r_state == DONE);
   assign out_bus   = r_outBus;
   assign op_err    = r_opErr;

endmodule

// File: tb/tb_p_logic_reduce.sv
// Testbench for p_logic_reduce: a 4-bit/3-operand instance and an
// 8-bit/1-operand instance, checked against a per-bit counting model.
module tb_p_logic_reduce;

   logic       clk;
   logic       rstN;

   // Instance A: BUS_WIDTH=4, NB_INS=3
   logic       inValidA;
   logic       inReadyA;
   logic [2:0] opA;
   logic [3:0] busesA [2:0];
   logic       outValidA;
   logic       outReadyA;
   logic [3:0] outBusA;
   logic       opErrA;
   logic       busyA;

   // Instance B: BUS_WIDTH=8, NB_INS=1
   logic       inValidB;
   logic       inReadyB;
   logic [2:0] opB;
   logic [7:0] busesB [0:0];
   logic       outValidB;
   logic       outReadyB;
   logic [7:0] outBusB;
   logic       opErrB;
   logic       busyB;

   int nCompared;
   int nMismatched;

   p_logic_reduce #(.BUS_WIDTH(4), .NB_INS(3)) dutA (
      .clk       (clk),
      .rst_n     (rstN),
      .in_valid  (inValidA),
      .in_ready  (inReadyA),
      .op        (opA),
      .in_buses  (busesA),
      .out_valid (outValidA),
      .out_ready (outReadyA),
      .out_bus   (outBusA),
      .op_err    (opErrA),
      .busy      (busyA)
   );

   p_logic_reduce #(.BUS_WIDTH(8), .NB_INS(1)) dutB (
      .clk       (clk),
      .rst_n     (rstN),
      .in_valid  (inValidB),
      .in_ready  (inReadyB),
      .op        (opB),
      .in_buses  (busesB),
      .out_valid (outValidB),
      .out_ready (outReadyB),
      .out_bus   (outBusB),
      .op_err    (opErrB),
      .busy      (busyB)
   );

   // Free-running clock, 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count a comparison and report it if it differs.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: each result bit depends only on how many operands have that
   // bit set (any / all / odd), optionally inverted.
   function automatic logic [7:0] refReduce(input logic [7:0] q[$], input int width,
                                            input logic [2:0] opc);
      logic [7:0] r;
      int         ones;
      r = '0;
      for (int b = 0; b < width; b++) begin
         ones = 0;
         foreach (q[k]) ones += int'(q[k][b]);
         case (opc)
            3'd0: r[b] = (ones > 0);
            3'd1: r[b] = (ones == q.size());
            3'd2: r[b] = (ones % 2 == 1);
            3'd3: r[b] = !(ones > 0);
            3'd4: r[b] = !(ones == q.size());
            3'd5: r[b] = !(ones % 2 == 1);
            default: r[b] = 1'b0;
         endcase
      end
      return r;
   endfunction

   // One full transaction on instance A: accept, latency, result, optional
   // backpressure with an ignored in_valid pulse, then the output handshake.
   task automatic applyStimulus(input logic [3:0] d0, input logic [3:0] d1,
                                input logic [3:0] d2, input logic [2:0] opc,
                                input int stall, input bit scramble,
                                input logic [3:0] expBus, input logic expErr);
      int cnt;
      cnt = 0;
      while (!inReadyA && cnt < 20) begin
         step();
         cnt++;
      end
      if (cnt >= 20) checkOutput("A in_ready timeout", 32'(inReadyA), 32'd1);
      busesA[0] = d0;
      busesA[1] = d1;
      busesA[2] = d2;
      opA       = opc;
      inValidA  = 1'b1;
      step();
      inValidA  = 1'b0;
      if (scramble) begin
         busesA[0] = 4'b0000;
         busesA[1] = 4'b0000;
         busesA[2] = 4'b0000;
         opA       = 3'($urandom_range(0, 7));
      end
      cnt = 1;
      while (!outValidA && cnt < 10) begin
         step();
         cnt++;
      end
      checkOutput("A latency", 32'(cnt), 32'd3);
      checkOutput("A out_bus", 32'(outBusA), 32'(expBus));
      checkOutput("A op_err", 32'(opErrA), 32'(expErr));
      for (int s = 0; s < stall; s++) begin
         if (s == 0) begin
            inValidA  = 1'b1;
            busesA[0] = 4'($urandom);
            busesA[1] = 4'($urandom);
            busesA[2] = 4'($urandom);
            opA       = 3'($urandom_range(0, 7));
         end
         step();
         inValidA = 1'b0;
         checkOutput("A hold out_bus", 32'(outBusA), 32'(expBus));
         checkOutput("A hold out_valid", 32'(outValidA), 32'd1);
         checkOutput("A hold in_ready", 32'(inReadyA), 32'd0);
         checkOutput("A hold busy", 32'(busyA), 32'd1);
      end
      outReadyA = 1'b1;
      step();
      outReadyA = 1'b0;
      checkOutput("A post out_valid", 32'(outValidA), 32'd0);
      checkOutput("A post out_bus", 32'(outBusA), 32'd0);
      checkOutput("A post op_err", 32'(opErrA), 32'd0);
      checkOutput("A post in_ready", 32'(inReadyA), 32'd1);
      checkOutput("A post busy", 32'(busyA), 32'd0);
   endtask

   // One transaction on the single-operand instance B.
   task automatic applyStimulusSingle(input logic [7:0] d0, input logic [2:0] opc,
                                      input logic [7:0] expBus, input logic expErr);
      int cnt;
      cnt = 0;
      while (!inReadyB && cnt < 20) begin
         step();
         cnt++;
      end
      if (cnt >= 20) checkOutput("B in_ready timeout", 32'(inReadyB), 32'd1);
      busesB[0] = d0;
      opB       = opc;
      inValidB  = 1'b1;
      step();
      inValidB  = 1'b0;
      busesB[0] = ~d0;
      checkOutput("B out_valid after accept", 32'(outValidB), 32'd1);
      checkOutput("B out_bus", 32'(outBusB), 32'(expBus));
      checkOutput("B op_err", 32'(opErrB), 32'(expErr));
      outReadyB = 1'b1;
      step();
      outReadyB = 1'b0;
      checkOutput("B post out_valid", 32'(outValidB), 32'd0);
      checkOutput("B post out_bus", 32'(outBusB), 32'd0);
   endtask

   // Main sequence: reset, directed cases, async reset abort, random cases.
   initial begin
      logic [3:0] dirExp [6];
      logic [7:0] q [$];
      logic [3:0] r0, r1, r2;
      logic [2:0] rop;
      logic [7:0] rb;

      nCompared   = 0;
      nMismatched = 0;
      dirExp[0] = 4'b1011;
      dirExp[1] = 4'b1001;
      dirExp[2] = 4'b1001;
      dirExp[3] = 4'b0100;
      dirExp[4] = 4'b0110;
      dirExp[5] = 4'b0110;

      rstN      = 1'b0;
      inValidA  = 1'b0;
      outReadyA = 1'b0;
      opA       = 3'd0;
      busesA[0] = 4'd0;
      busesA[1] = 4'd0;
      busesA[2] = 4'd0;
      inValidB  = 1'b0;
      outReadyB = 1'b0;
      opB       = 3'd0;
      busesB[0] = 8'd0;

      step();
      step();
      checkOutput("reset out_valid", 32'(outValidA), 32'd0);
      checkOutput("reset in_ready", 32'(inReadyA), 32'd0);
      checkOutput("reset busy", 32'(busyA), 32'd0);
      checkOutput("reset out_bus", 32'(outBusA), 32'd0);
      checkOutput("reset op_err", 32'(opErrA), 32'd0);
      rstN = 1'b1;
      #1;
      checkOutput("release in_ready", 32'(inReadyA), 32'd1);

      // Six defined operators on the reference operand set.
      for (int k = 0; k < 6; k++) begin
         applyStimulus(4'b1001, 4'b1011, 4'b1011, 3'(k), 0, 1'b0, dirExp[k], 1'b0);
      end
      // Backpressure with an ignored new request.
      applyStimulus(4'b1001, 4'b1011, 4'b1011, 3'd0, 5, 1'b0, 4'b1011, 1'b0);
      // Inputs change right after accept.
      applyStimulus(4'b1001, 4'b1011, 4'b1011, 3'd1, 0, 1'b1, 4'b1001, 1'b0);
      // Reserved operator.
      applyStimulus(4'b1001, 4'b1011, 4'b1011, 3'd7, 2, 1'b0, 4'b0000, 1'b1);

      // Asynchronous reset in the middle of folding.
      busesA[0] = 4'b1001;
      busesA[1] = 4'b1011;
      busesA[2] = 4'b1011;
      opA       = 3'd0;
      inValidA  = 1'b1;
      step();
      inValidA  = 1'b0;
      step();
      checkOutput("fold busy", 32'(busyA), 32'd1);
      #2;
      rstN = 1'b0;
      #1;
      checkOutput("abort out_valid", 32'(outValidA), 32'd0);
      checkOutput("abort busy", 32'(busyA), 32'd0);
      checkOutput("abort in_ready", 32'(inReadyA), 32'd0);
      checkOutput("abort out_bus", 32'(outBusA), 32'd0);
      checkOutput("abort op_err", 32'(opErrA), 32'd0);
      step();
      step();
      rstN = 1'b1;
      #1;
      checkOutput("rerelease in_ready", 32'(inReadyA), 32'd1);
      applyStimulus(4'b1001, 4'b1011, 4'b1011, 3'd0, 0, 1'b0, 4'b1011, 1'b0);

      // Single-operand instance.
      applyStimulusSingle(8'b10100101, 3'd4, 8'b01011010, 1'b0);
      applyStimulusSingle(8'b10100101, 3'd0, 8'b10100101, 1'b0);

      // Randomized transactions on both instances.
      for (int t = 0; t < 30; t++) begin
         r0  = 4'($urandom);
         r1  = 4'($urandom);
         r2  = 4'($urandom);
         rop = 3'($urandom_range(0, 7));
         q   = {};
         q.push_back(8'(r0));
         q.push_back(8'(r1));
         q.push_back(8'(r2));
         applyStimulus(r0, r1, r2, rop, int'($urandom_range(0, 3)), 1'($urandom),
                       refReduce(q, 4, rop)[3:0], (rop >= 3'd6));
      end
      for (int t = 0; t < 10; t++) begin
         rb  = 8'($urandom);
         rop = 3'($urandom_range(0, 7));
         q   = {};
         q.push_back(rb);
         applyStimulusSingle(rb, rop, refReduce(q, 8, rop), (rop >= 3'd6));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
